// File: rtl/reg_file.sv
// reg_file: 32 x DATA_W MIPS general-purpose register file.
// Two combinational read ports with optional same-cycle write forwarding,
// one synchronous write port, an unbypassed debug read port and a
// committed-write counter. Register $0 always reads as zero.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter bit          BYPASS = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [4:0]        DbgReg,
  output logic [DATA_W-1:0] DbgData,
  output logic [CNT_W-1:0]  WrCount
);

  logic [DATA_W-1:0] regs [0:31];
  logic [CNT_W-1:0]  wr_count;
  logic              wr_en;

  // A write commits only outside reset and never to $0.
  assign wr_en   = RegWrite && !Reset && (WriteReg != 5'd0);
  assign WrCount = wr_count;

  // Register array and committed-write counter; reset wins over a write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs     <= '{default: '0};
      wr_count <= '0;
    end else if (wr_en) begin
      regs[WriteReg] <= WriteData;
      wr_count       <= wr_count + CNT_W'(1);
    end
  end

  // Combinational read ports: forced to zero in reset, $0 masked, optional forwarding.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    DbgData   = '0;
    if (!Reset) begin
      if (ReadReg1 != 5'd0) ReadData1 = regs[ReadReg1];
      if (ReadReg2 != 5'd0) ReadData2 = regs[ReadReg2];
      if (DbgReg   != 5'd0) DbgData   = regs[DbgReg];
      if (BYPASS && wr_en && (WriteReg == ReadReg1)) ReadData1 = WriteData;
      if (BYPASS && wr_en && (WriteReg == ReadReg2)) ReadData2 = WriteData;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. Two instances share stimulus:
// one unbypassed with a 16-bit counter, one bypassed with a 4-bit counter.
module tb_reg_file;

  logic        clk = 1'b1;
  logic        rst, we;
  logic [4:0]  wa, ra1, ra2, dbg;
  logic [31:0] wd;

  logic [31:0] nb_rd1, nb_rd2, nb_dbg, by_rd1, by_rd2, by_dbg;
  logic [15:0] nb_cnt;
  logic [3:0]  by_cnt;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .BYPASS(1'b0), .CNT_W(16)) u_nb (
    .Clk(clk), .Reset(rst), .RegWrite(we), .WriteReg(wa), .WriteData(wd),
    .ReadReg1(ra1), .ReadReg2(ra2), .ReadData1(nb_rd1), .ReadData2(nb_rd2),
    .DbgReg(dbg), .DbgData(nb_dbg), .WrCount(nb_cnt));

  reg_file #(.DATA_W(32), .BYPASS(1'b1), .CNT_W(4)) u_by (
    .Clk(clk), .Reset(rst), .RegWrite(we), .WriteReg(wa), .WriteData(wd),
    .ReadReg1(ra1), .ReadReg2(ra2), .ReadData1(by_rd1), .ReadData2(by_rd2),
    .DbgReg(dbg), .DbgData(by_dbg), .WrCount(by_cnt));

  typedef struct {
    logic [31:0] r1n, r2n, r1b, r2b, dg;
    logic [15:0] c16;
    logic [3:0]  c4;
    bit          ck_cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int unsigned mcnt;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural read as seen by a port: zero in reset, forwarding if enabled.
  function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
    if (rst) return 32'h0;
    if (byp && we && wa != 5'd0 && wa == a) return wd;
    if (a == 5'd0) return 32'h0;
    return mregs[a];
  endfunction

  // Drive inputs, queue expectations, then advance the model to the next edge.
  task automatic apply(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] dg,
                       input bit ck_cnt);
    exp_t e;
    rst = r; we = w; wa = a; wd = d; ra1 = x1; ra2 = x2; dbg = dg;
    e.r1n    = model_read(x1, 1'b0);
    e.r2n    = model_read(x2, 1'b0);
    e.r1b    = model_read(x1, 1'b1);
    e.r2b    = model_read(x2, 1'b1);
    e.dg     = model_read(dg, 1'b0);
    e.c16    = 16'(mcnt % 65536);
    e.c4     = 4'(mcnt % 16);
    e.ck_cnt = ck_cnt;
    sb.push_back(e);
    if (r) begin
      foreach (mregs[i]) mregs[i] = 32'h0;
      mcnt = 0;
    end else if (w && a != 5'd0) begin
      mregs[a] = d;
      mcnt++;
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] dg);
    @(posedge clk);
    #1;
    apply(r, w, a, d, x1, x2, dg, 1'b1);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rd1_nobyp", nb_rd1, e.r1n);
        check("rd2_nobyp", nb_rd2, e.r2n);
        check("rd1_byp",   by_rd1, e.r1b);
        check("rd2_byp",   by_rd2, e.r2b);
        check("dbg_nobyp", nb_dbg, e.dg);
        check("dbg_byp",   by_dbg, e.dg);
        if (e.ck_cnt) begin
          check("wrcount16", {16'h0, nb_cnt}, {16'h0, e.c16});
          check("wrcount4",  {28'h0, by_cnt}, {28'h0, e.c4});
        end
      end
    end
  end

  initial begin
    logic [4:0]  a, x1, x2;
    logic [31:0] d;
    foreach (mregs[i]) mregs[i] = 32'h0;
    mcnt = 0;

    // Reset asserted before any clock edge: reads forced to zero, counter not yet defined.
    apply(1'b1, 1'b1, 5'd3, 32'h1111_2222, 5'd3, 5'd4, 5'd5, 1'b0);

    // Preload every register, then reset with a coincident write to r7.
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), $urandom, 5'(i), 5'(32 - i), 5'(i));
    step(1'b1, 1'b1, 5'd7, 32'hAAAA_5555, 5'd7, 5'd7, 5'd7);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));

    // Basic write/read and WrCount.
    step(1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd31, 32'h1234_5678, 5'd5, 5'd31, 5'd5);
    step(1'b0, 1'b0, 5'd0,  32'h0, 5'd5, 5'd31, 5'd31);

    // Writes to $0 are dropped and not counted.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 5'd0);

    // Same-cycle forwarding on both ports, then the committed value.
    step(1'b0, 1'b1, 5'd9, 32'h0000_CAFE, 5'd9, 5'd9, 5'd9);
    step(1'b0, 1'b0, 5'd9, 32'h0, 5'd9, 5'd9, 5'd9);

    // Counter wrap: 17 writes to r1 after reset.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 5'd1, $urandom, 5'd1, 5'd2, 5'd1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 5'd1);

    // Randomised traffic with frequent read/write index collisions.
    for (int i = 0; i < 400; i++) begin
      a  = 5'($urandom_range(0, 31));
      d  = $urandom;
      x1 = ($urandom_range(0, 1) == 1) ? a : 5'($urandom_range(0, 31));
      x2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), a, d, x1, x2,
           5'($urandom_range(0, 31)));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int unsigned k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
